i2s_tx: RTL



---
 rtl/i2s_tx.sv | 134 +++++++++++++
 1 files changed

// File: rtl/i2s_tx.sv
// i2s_tx: I2S master transmitter driving a stereo DAC.
// Generates scki (clk/2), bck and lrck from clk. It serialises left/right
// sample pairs MSB first, with the standard one-bck delay after each lrck edge.
// Upstream delivers pairs through a valid/ready handshake into a one-pair
// holding register. At each frame boundary the held pair moves to the active
// registers, which the serialiser reads throughout the following frame.
// Optional build macro: I2S_TX_UNDERRUN_HOLD_EN. When it is defined, an
// underrun retransmits the previous pair. When it is undefined, an underrun
// sends silence.
module i2s_tx #(
   parameter int WIDTH   = 24,
   parameter int BCK_DIV = 4,
   parameter int SLOT    = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] left,
   input  logic [WIDTH-1:0] right,
   input  logic             in_valid,
   output logic             in_ready,
   output logic             scki,
   output logic             bck,
   output logic             lrck,
   output logic             dout,
   output logic             frame_start,
   output logic             underrun,
   input  logic             clr_underrun
);

   localparam int DW = (BCK_DIV > 2) ? $clog2(BCK_DIV) : 1;
   localparam int BW = $clog2(2 * SLOT);
   localparam int IW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

   logic [DW-1:0]    divcnt, divcnt_nxt;
   logic [BW-1:0]    bitcnt, bitcnt_nxt, pos;
   logic             wrap, frame_end, boundary, chan_r, dout_nxt, underrun_set;
   logic [WIDTH-1:0] hold_l, hold_r, act_l, act_r, sample;
   logic [IW-1:0]    idx;

   assign wrap       = (divcnt == DW'(BCK_DIV - 1));
   assign divcnt_nxt = wrap ? '0 : divcnt + 1'b1;
   assign frame_end  = (bitcnt == BW'(2 * SLOT - 1));
   assign boundary   = wrap & frame_end;
   assign bitcnt_nxt = frame_end ? '0 : bitcnt + 1'b1;
   // A frame boundary with nothing held and nothing offered is an underrun.
   // in_ready doubles as the "holding empty" flag.
   assign underrun_set = boundary & in_ready & ~in_valid;

   // Channel and slot position of the bit that goes out after this wrap
   always_comb begin
      chan_r   = (bitcnt_nxt >= BW'(SLOT));
      pos      = chan_r ? bitcnt_nxt - BW'(SLOT) : bitcnt_nxt;
      sample   = chan_r ? act_r : act_l;
      idx      = IW'(WIDTH - int'(pos));
      dout_nxt = 1'b0;
      if (pos != '0 && pos <= BW'(WIDTH))
         dout_nxt = sample[idx];
   end

   // Clock generation: scki toggles each clk, bck is derived from divcnt
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         scki   <= 1'b0;
         divcnt <= '0;
         bck    <= 1'b0;
      end else begin
         scki   <= ~scki;
         divcnt <= divcnt_nxt;
         bck    <= (divcnt_nxt >= DW'(BCK_DIV / 2));
      end
   end

   // Bit position, word select and serial data advance on bck falling
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bitcnt      <= '0;
         lrck        <= 1'b0;
         dout        <= 1'b0;
         frame_start <= 1'b0;
      end else begin
         frame_start <= boundary;
         if (wrap) begin
            bitcnt <= bitcnt_nxt;
            lrck   <= chan_r;
            dout   <= dout_nxt;
         end
      end
   end

   // Handshake into the holding register and frame-boundary transfer to active
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         in_ready <= 1'b1;
         hold_l   <= '0;
         hold_r   <= '0;
         act_l    <= '0;
         act_r    <= '0;
      end else if (boundary) begin
         if (!in_ready) begin
            act_l    <= hold_l;
            act_r    <= hold_r;
            in_ready <= 1'b1;
         end else if (in_valid) begin
            // Holding is empty: the offered pair goes straight to active
            act_l <= left;
            act_r <= right;
         end else begin
`ifdef I2S_TX_UNDERRUN_HOLD_EN
            // Keep the previous pair so that it is retransmitted
            act_l <= act_l;
            act_r <= act_r;
`else
            act_l <= '0;
            act_r <= '0;
`endif
         end
      end else if (in_valid && in_ready) begin
         hold_l   <= left;
         hold_r   <= right;
         in_ready <= 1'b0;
      end
   end

   // Sticky underrun flag; a new underrun wins over a clear in the same cycle
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         underrun <= 1'b0;
      else if (underrun_set)
         underrun <= 1'b1;
      else if (clr_underrun)
         underrun <= 1'b0;
   end

endmodule
